rt_ibex_window_ctrl: RTL and testbench
======================================

Name: rt_ibex_window_ctrl

Overview:
- Interrupt-nesting sequencer that drives the windowed register file's control side.
- Drives `increment_ptr`, `decrement_ptr` and `save_csr`, and supplies the `mcause`/`mepc` values to be banked.
- On `mret` it reads back the banked `mcause`/`mepc` and restores them to the CSR file.
- Tracks nesting depth and, per level, whether that level received a register window. When the file is full, entry falls back to non-windowed (software-saved) handling.

Parameters:
- `MaxNest`, 8, maximum tracked interrupt nesting depth (≥1).
- `NumRegisterWindows`, 4, register-window count of the attached file; used only for the outstanding-window assertion.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `irq_enter_req_i`  in  1  core is taking an interrupt; held until ack
- `irq_enter_ack_o`  out  1  single-cycle entry completion
- `mret_req_i`  in  1  core is retiring mret; held until ack
- `mret_ack_o`  out  1  single-cycle exit completion
- `csr_mcause_i`  in  32  current mcause to bank
- `csr_mepc_i`  in  32  current mepc to bank
- `rf_window_full_i`  in  1  register file has no free window
- `rf_increment_ptr_o`  out  1  advance window/aux pointer
- `rf_decrement_ptr_o`  out  1  retreat window/aux pointer
- `rf_save_csr_o`  out  1  bank CSR data into aux slot
- `rf_mcause_o`  out  32  mcause to bank
- `rf_mepc_o`  out  32  mepc to bank
- `rf_mcause_i`  in  32  banked mcause at current aux pointer
- `rf_mepc_i`  in  32  banked mepc at current aux pointer
- `csr_restore_o`  out  1  write restored values to CSR file this cycle
- `csr_mcause_o`  out  32  restored mcause
- `csr_mepc_o`  out  32  restored mepc
- `nest_depth_o`  out  $clog2(MaxNest+1)  current nesting depth
- `windowed_o`  out  1  current level owns a window
- `overflow_o`  out  1  sticky: entry attempted at depth==MaxNest
- `underflow_o`  out  1  sticky: mret at depth 0

Behaviour:

Reset:
- All outputs are 0; state IDLE; depth 0; window stack (MaxNest bits) cleared; capture registers 0.
- A reset mid-sequence aborts it with no further pulses. The register file shares `rst_ni`, so its pointers are also 0.

State machine (states IDLE, SAVE, ADV, RET, RESTORE, ACK):
- **IDLE:**
  - If `irq_enter_req_i` is high, entry is taken. Entry has priority when both requests are high.
  - Otherwise, if `mret_req_i` is high, exit is taken.
- **Entry:**
  - If depth==MaxNest: set `overflow_o`, go to ACK with no push.
  - Else if `!rf_window_full_i`: capture `csr_mcause_i`/`csr_mepc_i` into `rf_mcause_o`/`rf_mepc_o`, go to SAVE.
  - Else: push 0, depth+1, go to ACK.
- **SAVE:** `rf_save_csr_o`=1 for exactly one cycle; go to ADV.
- **ADV:**
  - `rf_increment_ptr_o`=1 and `irq_enter_ack_o`=1 in the same cycle.
  - Push 1, depth+1; go to IDLE.
  - Windowed entry latency: ack 2 cycles after the request is sampled.
- **Exit:**
  - If depth==0: set `underflow_o`, go to ACK.
  - Else if the top-of-stack bit is 1: go to RET.
  - Else: pop, depth−1, go to ACK.
- **RET:** `rf_decrement_ptr_o`=1 for one cycle; go to RESTORE.
- **RESTORE:**
  - `csr_restore_o`=1 and `mret_ack_o`=1.
  - `csr_mcause_o`/`csr_mepc_o` = `rf_mcause_i`/`rf_mepc_i`, sampled combinationally after the decrement has taken effect.
  - Pop, depth−1; go to IDLE.
- **ACK:** assert the ack matching the latched request kind for one cycle; go to IDLE.

Rules and invariants:
- Requests are ignored outside IDLE.
- A request still high in the cycle after its ack is treated as a new request.
- At most one of `rf_increment_ptr_o`, `rf_decrement_ptr_o`, `rf_save_csr_o` is high in any cycle.
- The count of 1s in the stack is never greater than NumRegisterWindows−1 (assertion).
- `windowed_o` = stack[depth−1] when depth>0, else 0.
- `csr_mcause_o`/`csr_mepc_o` are 0 when `csr_restore_o`=0.
- Sticky flags clear only on reset.

Test Plan:
1. Entry with `csr_mcause_i`=0x8000_0007, `csr_mepc_i`=0x100, window not full → `rf_save_csr_o` on cycle 1 carrying those values, `rf_increment_ptr_o` + ack on cycle 2, depth=1, `windowed_o`=1.
2. Following mret with `rf_mcause_i`=0x8000_0007, `rf_mepc_i`=0x100 → `rf_decrement_ptr_o` on cycle 1, restore + ack on cycle 2 with those values, depth=0.
3. Entry three times with `rf_window_full_i` asserted after the 3rd increment, then a 4th entry → 4th acks via ACK with no pointer or save pulse, `windowed_o`=0, depth=4. Four mrets then produce exactly three decrements, in the correct LIFO order.
4. With MaxNest=2, a third entry → `overflow_o`=1, ack given, depth stays 2. An mret at depth 0 → `underflow_o`=1, ack given, no `rf_*` pulses.
5. `irq_enter_req_i` and `mret_req_i` both high in IDLE at depth 1 → entry is processed first, and the mret is processed after the entry ack.
6. Assert `rst_ni`=0 during SAVE → all outputs 0 immediately, depth 0; after release, no `increment_ptr` pulse is issued.

Source files
------------

// File: rtl/rt_ibex_window_ctrl.sv
// ============================================================================
// Module   : rt_ibex_window_ctrl
// Brief    : Interrupt-nesting sequencer for a windowed register file. It banks
//            and restores mcause/mepc and tracks which nesting levels own a window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rt_ibex_window_ctrl #(
    parameter int MaxNest            = 8,
    parameter int NumRegisterWindows = 4,
    localparam int DW                = $clog2(MaxNest + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          irq_enter_req_i,
    output logic          irq_enter_ack_o,
    input  logic          mret_req_i,
    output logic          mret_ack_o,
    input  logic [31:0]   csr_mcause_i,
    input  logic [31:0]   csr_mepc_i,
    input  logic          rf_window_full_i,
    output logic          rf_increment_ptr_o,
    output logic          rf_decrement_ptr_o,
    output logic          rf_save_csr_o,
    output logic [31:0]   rf_mcause_o,
    output logic [31:0]   rf_mepc_o,
    input  logic [31:0]   rf_mcause_i,
    input  logic [31:0]   rf_mepc_i,
    output logic          csr_restore_o,
    output logic [31:0]   csr_mcause_o,
    output logic [31:0]   csr_mepc_o,
    output logic [DW-1:0] nest_depth_o,
    output logic          windowed_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        ADV     = 3'd2,
        RET     = 3'd3,
        RESTORE = 3'd4,
        ACK     = 3'd5
    } state_e;

    localparam logic [DW-1:0] C_MAX_DEPTH = DW'(MaxNest);

    state_e             state_q, state_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [MaxNest-1:0] stack_q, stack_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mepc_q, mepc_d;
    logic               save_q, save_d;
    logic               inc_q, inc_d;
    logic               dec_q, dec_d;
    logic               restore_q, restore_d;
    logic               irq_ack_q, irq_ack_d;
    logic               mret_ack_q, mret_ack_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               w_top;

    // Window-ownership bit of the innermost active level.
    always_comb begin
        w_top = 1'b0;
        for (int i = 0; i < MaxNest; i++) begin
            if (depth_q != '0 && i == int'(depth_q) - 1) begin
                w_top = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        stack_d    = stack_q;
        mcause_d   = mcause_q;
        mepc_d     = mepc_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        save_d     = 1'b0;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        restore_d  = 1'b0;
        irq_ack_d  = 1'b0;
        mret_ack_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (irq_enter_req_i) begin
                    if (depth_q == C_MAX_DEPTH) begin
                        ovf_d     = 1'b1;
                        irq_ack_d = 1'b1;
                        state_d   = ACK;
                    end else if (!rf_window_full_i) begin
                        mcause_d = csr_mcause_i;
                        mepc_d   = csr_mepc_i;
                        save_d   = 1'b1;
                        state_d  = SAVE;
                    end else begin
                        for (int i = 0; i < MaxNest; i++) begin
                            if (i == int'(depth_q)) stack_d[i] = 1'b0;
                        end
                        depth_d   = depth_q + 1'b1;
                        irq_ack_d = 1'b1;
                        state_d   = ACK;
                    end
                end else if (mret_req_i) begin
                    if (depth_q == '0) begin
                        unf_d      = 1'b1;
                        mret_ack_d = 1'b1;
                        state_d    = ACK;
                    end else if (w_top) begin
                        dec_d   = 1'b1;
                        state_d = RET;
                    end else begin
                        for (int i = 0; i < MaxNest; i++) begin
                            if (i == int'(depth_q) - 1) stack_d[i] = 1'b0;
                        end
                        depth_d    = depth_q - 1'b1;
                        mret_ack_d = 1'b1;
                        state_d    = ACK;
                    end
                end
            end
            SAVE: begin
                inc_d     = 1'b1;
                irq_ack_d = 1'b1;
                state_d   = ADV;
            end
            ADV: begin
                for (int i = 0; i < MaxNest; i++) begin
                    if (i == int'(depth_q)) stack_d[i] = 1'b1;
                end
                depth_d = depth_q + 1'b1;
                state_d = IDLE;
            end
            RET: begin
                restore_d  = 1'b1;
                mret_ack_d = 1'b1;
                state_d    = RESTORE;
            end
            RESTORE: begin
                for (int i = 0; i < MaxNest; i++) begin
                    if (i == int'(depth_q) - 1) stack_d[i] = 1'b0;
                end
                depth_d = depth_q - 1'b1;
                state_d = IDLE;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            depth_q    <= '0;
            stack_q    <= '0;
            mcause_q   <= '0;
            mepc_q     <= '0;
            save_q     <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            restore_q  <= 1'b0;
            irq_ack_q  <= 1'b0;
            mret_ack_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            stack_q    <= stack_d;
            mcause_q   <= mcause_d;
            mepc_q     <= mepc_d;
            save_q     <= save_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            restore_q  <= restore_d;
            irq_ack_q  <= irq_ack_d;
            mret_ack_q <= mret_ack_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign irq_enter_ack_o    = irq_ack_q;
    assign mret_ack_o         = mret_ack_q;
    assign rf_save_csr_o      = save_q;
    assign rf_increment_ptr_o = inc_q;
    assign rf_decrement_ptr_o = dec_q;
    assign rf_mcause_o        = mcause_q;
    assign rf_mepc_o          = mepc_q;
    // Banked values are read live: the pointer has already retreated in RET.
    assign csr_restore_o      = restore_q;
    assign csr_mcause_o       = restore_q ? rf_mcause_i : 32'h0;
    assign csr_mepc_o         = restore_q ? rf_mepc_i : 32'h0;
    assign nest_depth_o       = depth_q;
    assign windowed_o         = w_top;
    assign overflow_o         = ovf_q;
    assign underflow_o        = unf_q;

    a_window_budget: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $countones(stack_q) <= NumRegisterWindows - 1);
    a_pulse_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({inc_q, dec_q, save_q}));

endmodule

`default_nettype wire

// File: tb/tb_rt_ibex_window_ctrl.sv
// ============================================================================
// Module   : tb_rt_ibex_window_ctrl
// Brief    : Scoreboard bench with a behavioural nesting model and a simple
//            register-file model supplying window-full and banked CSR data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rt_ibex_window_ctrl;

    localparam int MAXN = 8;
    localparam int NRW  = 4;
    localparam int DW   = $clog2(MAXN + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          irq_enter_req_i;
    logic          irq_enter_ack_o;
    logic          mret_req_i;
    logic          mret_ack_o;
    logic [31:0]   csr_mcause_i;
    logic [31:0]   csr_mepc_i;
    logic          rf_window_full_i;
    logic          rf_increment_ptr_o;
    logic          rf_decrement_ptr_o;
    logic          rf_save_csr_o;
    logic [31:0]   rf_mcause_o;
    logic [31:0]   rf_mepc_o;
    logic [31:0]   rf_mcause_i;
    logic [31:0]   rf_mepc_i;
    logic          csr_restore_o;
    logic [31:0]   csr_mcause_o;
    logic [31:0]   csr_mepc_o;
    logic [DW-1:0] nest_depth_o;
    logic          windowed_o;
    logic          overflow_o;
    logic          underflow_o;

    rt_ibex_window_ctrl #(.MaxNest(MAXN), .NumRegisterWindows(NRW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .irq_enter_req_i    (irq_enter_req_i),
        .irq_enter_ack_o    (irq_enter_ack_o),
        .mret_req_i         (mret_req_i),
        .mret_ack_o         (mret_ack_o),
        .csr_mcause_i       (csr_mcause_i),
        .csr_mepc_i         (csr_mepc_i),
        .rf_window_full_i   (rf_window_full_i),
        .rf_increment_ptr_o (rf_increment_ptr_o),
        .rf_decrement_ptr_o (rf_decrement_ptr_o),
        .rf_save_csr_o      (rf_save_csr_o),
        .rf_mcause_o        (rf_mcause_o),
        .rf_mepc_o          (rf_mepc_o),
        .rf_mcause_i        (rf_mcause_i),
        .rf_mepc_i          (rf_mepc_i),
        .csr_restore_o      (csr_restore_o),
        .csr_mcause_o       (csr_mcause_o),
        .csr_mepc_o         (csr_mepc_o),
        .nest_depth_o       (nest_depth_o),
        .windowed_o         (windowed_o),
        .overflow_o         (overflow_o),
        .underflow_o        (underflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Register-file side: aux slot per pointer, full when the last window is reached.
    int          rf_ptr;
    bit          force_full;
    logic [31:0] aux_mc   [0:15];
    logic [31:0] aux_mepc [0:15];

    initial begin
        for (int i = 0; i < 16; i++) begin
            aux_mc[i]   = 32'h0;
            aux_mepc[i] = 32'h0;
        end
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_ptr <= 0;
        end else begin
            if (rf_save_csr_o) begin
                aux_mc[rf_ptr[3:0]]   <= rf_mcause_o;
                aux_mepc[rf_ptr[3:0]] <= rf_mepc_o;
            end
            if (rf_increment_ptr_o) rf_ptr <= rf_ptr + 1;
            if (rf_decrement_ptr_o) rf_ptr <= rf_ptr - 1;
        end
    end

    assign rf_window_full_i = (rf_ptr >= NRW - 1) || force_full;
    assign rf_mcause_i      = aux_mc[rf_ptr[3:0]];
    assign rf_mepc_i        = aux_mepc[rf_ptr[3:0]];

    typedef struct {
        bit          entry;
        int          n_save;
        int          n_inc;
        int          n_dec;
        bit          restore;
        logic [31:0] mc;
        logic [31:0] mepc;
        int          depth;
        bit          win;
        bit          ovf;
        bit          unf;
    } exp_t;

    typedef struct {
        bit          win;
        logic [31:0] mc;
        logic [31:0] mepc;
    } lvl_t;

    lvl_t m_stack[$];
    exp_t sb[$];
    int   m_windows;
    bit   m_ovf;
    bit   m_unf;
    int   n_pass;
    int   n_chk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    function automatic exp_t finish_exp(input exp_t e);
        exp_t r;
        r       = e;
        r.depth = m_stack.size();
        r.win   = (m_stack.size() > 0) ? m_stack[$].win : 1'b0;
        r.ovf   = m_ovf;
        r.unf   = m_unf;
        return r;
    endfunction

    task automatic expect_entry(input logic [31:0] mc, input logic [31:0] mepc);
        exp_t e;
        lvl_t l;
        e = '{default: 0};
        e.entry = 1'b1;
        if (m_stack.size() == MAXN) begin
            m_ovf = 1'b1;
        end else if (!(m_windows >= NRW - 1 || force_full)) begin
            e.n_save = 1;
            e.n_inc  = 1;
            e.mc     = mc;
            e.mepc   = mepc;
            l = '{win: 1'b1, mc: mc, mepc: mepc};
            m_stack.push_back(l);
            m_windows++;
        end else begin
            l = '{win: 1'b0, mc: 32'h0, mepc: 32'h0};
            m_stack.push_back(l);
        end
        sb.push_back(finish_exp(e));
    endtask

    task automatic expect_exit();
        exp_t e;
        lvl_t l;
        e = '{default: 0};
        if (m_stack.size() == 0) begin
            m_unf = 1'b1;
        end else begin
            l = m_stack.pop_back();
            if (l.win) begin
                e.n_dec   = 1;
                e.restore = 1'b1;
                e.mc      = l.mc;
                e.mepc    = l.mepc;
                m_windows--;
            end
        end
        sb.push_back(finish_exp(e));
    endtask

    task automatic wait_ack(input bit is_irq);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (is_irq ? irq_enter_ack_o : mret_ack_o) got = 1'b1;
        end
        if (!got) chk(is_irq ? "irq_ack_timeout" : "mret_ack_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        if (is_irq) irq_enter_req_i = 1'b0;
        else        mret_req_i      = 1'b0;
    endtask

    task automatic issue(input bit do_irq, input bit do_mret,
                         input logic [31:0] mc, input logic [31:0] mepc);
        @(posedge clk_i);
        #1;
        csr_mcause_i = mc;
        csr_mepc_i   = mepc;
        if (do_irq)  expect_entry(mc, mepc);
        if (do_mret) expect_exit();
        irq_enter_req_i = do_irq;
        mret_req_i      = do_mret;
        if (do_irq)  wait_ack(1'b1);
        if (do_mret) wait_ack(1'b0);
    endtask

    function automatic logic [15:0] ctrl_bits();
        return {irq_enter_ack_o, mret_ack_o, rf_increment_ptr_o, rf_decrement_ptr_o,
                rf_save_csr_o, csr_restore_o, windowed_o, overflow_o, underflow_o,
                3'b000, nest_depth_o};
    endfunction

    // Monitor: tallies pulses between acks and scores each ack against the queue.
    initial begin
        int          n_save, n_inc, n_dec;
        bit          multi, pending;
        logic [31:0] sv_mc, sv_mepc;
        exp_t        e, pend;
        n_save = 0; n_inc = 0; n_dec = 0; multi = 0; pending = 0;
        sv_mc = 0; sv_mepc = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                sb.delete();
                pending = 0; n_save = 0; n_inc = 0; n_dec = 0; multi = 0;
            end else begin
                if (pending) begin
                    chk("depth_state", {nest_depth_o, windowed_o, overflow_o, underflow_o},
                        {DW'(pend.depth), pend.win, pend.ovf, pend.unf});
                    pending = 0;
                end
                if (rf_save_csr_o) begin
                    n_save++;
                    sv_mc   = rf_mcause_o;
                    sv_mepc = rf_mepc_o;
                end
                if (rf_increment_ptr_o) n_inc++;
                if (rf_decrement_ptr_o) n_dec++;
                if (int'(rf_save_csr_o) + int'(rf_increment_ptr_o) + int'(rf_decrement_ptr_o) > 1)
                    multi = 1;
                if (irq_enter_ack_o || mret_ack_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", {irq_enter_ack_o, mret_ack_o}, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_kind", {irq_enter_ack_o, mret_ack_o}, e.entry ? 2'b10 : 2'b01);
                        chk("pulses", {8'(n_save), 8'(n_inc), 8'(n_dec), 7'd0, multi},
                            {8'(e.n_save), 8'(e.n_inc), 8'(e.n_dec), 8'd0});
                        if (e.n_save != 0)
                            chk("save_data", {sv_mc, sv_mepc}, {e.mc, e.mepc});
                        chk("restore", {csr_restore_o, csr_mcause_o, csr_mepc_o},
                            {e.restore, e.restore ? e.mc : 32'h0, e.restore ? e.mepc : 32'h0});
                        pend    = e;
                        pending = 1;
                    end
                    n_save = 0; n_inc = 0; n_dec = 0; multi = 0;
                end
            end
        end
    end

    initial begin
        int n_inc_seen;
        bit got;
        n_pass = 0; n_chk = 0;
        m_windows = 0; m_ovf = 0; m_unf = 0;
        force_full = 1'b0;
        rst_ni = 1'b0;
        irq_enter_req_i = 1'b0;
        mret_req_i = 1'b0;
        csr_mcause_i = 32'h0;
        csr_mepc_i = 32'h0;
        #1;
        chk("reset_ctrl", ctrl_bits(), 16'h0);
        chk("reset_data", {rf_mcause_o, rf_mepc_o, csr_mcause_o}, 96'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single windowed entry then its mret.
        issue(1'b1, 1'b0, 32'h8000_0007, 32'h0000_0100);
        issue(1'b0, 1'b1, 32'h0, 32'h0);

        // Fill windows, fall back, overflow, then unwind past the bottom.
        for (int i = 0; i < MAXN + 1; i++)
            issue(1'b1, 1'b0, 32'h8000_0010 + i, 32'h0000_2000 + 32'(i * 4));
        for (int i = 0; i < MAXN + 1; i++)
            issue(1'b0, 1'b1, 32'h0, 32'h0);

        // Simultaneous requests at depth 1.
        issue(1'b1, 1'b0, 32'h0000_000B, 32'h0000_3000);
        issue(1'b1, 1'b1, 32'h0000_000C, 32'h0000_3004);
        while (m_stack.size() > 0) issue(1'b0, 1'b1, 32'h0, 32'h0);

        // Reset while the save pulse is out.
        @(posedge clk_i);
        #1;
        csr_mcause_i = 32'h1234_5678;
        csr_mepc_i   = 32'h0000_4000;
        irq_enter_req_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (rf_save_csr_o) got = 1'b1;
        end
        chk("save_before_reset", got, 1'b1);
        #2;
        rst_ni = 1'b0;
        irq_enter_req_i = 1'b0;
        #1;
        chk("midreset_ctrl", ctrl_bits(), 16'h0);
        chk("midreset_data", {rf_mcause_o, rf_mepc_o, csr_mcause_o}, 96'h0);
        m_stack.delete();
        m_windows = 0; m_ovf = 0; m_unf = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        n_inc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (rf_increment_ptr_o) n_inc_seen++;
        end
        chk("no_inc_after_reset", n_inc_seen, 0);

        // Randomised traffic.
        for (int t = 0; t < 80; t++) begin
            int r;
            force_full = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            if (r < 5)      issue(1'b1, 1'b0, $urandom, $urandom);
            else if (r < 9) issue(1'b0, 1'b1, 32'h0, 32'h0);
            else            issue(1'b1, 1'b1, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end
        repeat (4) @(posedge clk_i);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
